gfx_scan_driver: RTL
====================

# gfx_scan_driver

Parametrised scan-timing generator that drives the graphics pipeline and double buffer. It produces pixel/line counters, blanking flags, framebuffer write address and enable, the per-frame buffer toggle, and a V-counter match flag for DISPSTAT. It sits between `graphics_top`/`double_buffer` and the MMIO block. It generalises the fixed 240x160, 4-clock-per-pixel driver to arbitrary geometry, adds stall, blanking and line-match outputs, and adds a single-shot frame mode.

## Interface
- `H_ACTIVE`, 240, visible pixels per line
- `V_ACTIVE`, 160, visible lines per frame
- `H_TOTAL`, 308, pixels per line including hblank (> `H_ACTIVE`)
- `V_TOTAL`, 228, lines per frame including vblank (> `V_ACTIVE`)
- `CPP`, 4, clocks per pixel (>= 1)
- `ADDR_W`, 17, framebuffer address width (2^ADDR_W >= H_ACTIVE*V_ACTIVE)
- `V_W`, 8, vcount/lyc width
- `CONTINUOUS`, 1, 1 = free-running; 0 = one frame per `start`

Ports:
- `clock` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `en` in 1: advance enable; when low, all counters hold
- `start` in 1: begin one frame (used only when `CONTINUOUS`=0)
- `lyc` in V_W: line compare value
- `hcount` out $clog2(H_TOTAL): current pixel in line
- `vcount` out V_W: current line
- `graphics_addr` out ADDR_W: linear framebuffer address of current active pixel
- `wen` out 1: framebuffer write strobe
- `hblank` out 1: hcount >= H_ACTIVE
- `vblank` out 1: vcount >= V_ACTIVE
- `hblank_start` out 1: one-cycle pulse entering hblank
- `vblank_start` out 1: one-cycle pulse entering vblank
- `toggle` out 1: one-cycle end-of-frame pulse (swap buffers)
- `vcount_match` out 1: vcount == lyc
- `busy` out 1: state is RUN

## Operation
- State machine, two states:
  - IDLE: counters held at 0.
  - RUN: counters advance.
- Reset places the machine in RUN if `CONTINUOUS`=1 and in IDLE otherwise.
- IDLE->RUN: on `start`=1; counting begins the next cycle.
- RUN->IDLE: taken only when `CONTINUOUS`=0, on the `toggle` cycle.
- A `start` pulse while in RUN is ignored.
- Counter `sub` runs 0..CPP-1 and advances when RUN & `en`. Define `last_sub` = (sub==CPP-1) & RUN & `en`.
- On `last_sub`, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. At V_TOTAL-1, vcount wraps to 0.
- `graphics_addr` is an incremental counter; no multiplier is used.
  - Increments on `last_sub` when active, where active = !hblank & !vblank.
  - Holds through blanking.
  - Clears to 0 on `toggle`.
  - Invariant: in the active region, `graphics_addr` == vcount*H_ACTIVE + hcount.
- Output decodes:
  - `wen` = active & `last_sub`, i.e. one write per pixel.
  - `hblank_start` = `last_sub` & hcount==H_ACTIVE-1.
  - `vblank_start` = `last_sub` & hcount==H_TOTAL-1 & vcount==V_ACTIVE-1.
  - `toggle` = `last_sub` & hcount==H_TOTAL-1 & vcount==V_TOTAL-1.
- `vcount_match` is a level signal, decoded combinationally from the registered vcount. It is valid in IDLE, where it compares against vcount=0.
- Simultaneous `toggle` and IDLE->RUN cannot occur, because `start` is ignored in RUN. With `CONTINUOUS`=0, a new frame requires a fresh `start` after `busy` falls.

## Timing
- All counters and state are registered. Every output is a combinational decode of registered state and `en`; no output is a bare input passthrough except through `en`.
- Reset (synchronous, highest priority):
  - sub, hcount, vcount and graphics_addr go to 0.
  - `busy` = CONTINUOUS.
  - All pulse outputs and `wen` are forced to 0 while `reset` is high.
- First pixel: with `en` held high, the first `wen` occurs CPP-1 cycles after reset deasserts, for address 0.
- Frame length is H_TOTAL*V_TOTAL*CPP enabled cycles. With defaults this is 280896, and `toggle` asserts on enabled cycle 280895 (counting from 0).
- Stall: `en`=0 freezes all state and suppresses every pulse. Resuming with `en`=1 continues exactly where counting stopped.
- CPP=1: `last_sub` = RUN & `en`, so `wen` is asserted on every active enabled cycle.
- Reset mid-frame: counters restart from 0 on the next cycle. No `toggle` is emitted for the aborted frame.

## Structure
- `gfx_scan_pkg` holds:
  - `typedef enum logic {IDLE, RUN} scan_state_t`.
  - Default GBA geometry constants: H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL and CPP.
- One sub-module, `scan_counter #(WIDTH, MAX)`:
  - Inputs `clock`, `reset`, `en`, `clear`.
  - Outputs `Q` and `last` (Q==MAX).
  - Priority: `reset` > `clear` > `!en` (hold) > `last` (wrap) > increment.
- The sub-module is instantiated for sub, hcount and vcount. `graphics_addr` is a separate register in the top.

## Test plan
- Defaults, `en`=1, CONTINUOUS=1, run 2 frames:
  - `wen` count per frame = 38400.
  - Last active `graphics_addr` = 38399 at vcount 159, hcount 239.
  - `toggle` is asserted on cycles 280895 and 561791.
  - `graphics_addr` = 0 after each `toggle`.
- Line boundary:
  - `hblank` rises when hcount=240, with `hblank_start` one cycle earlier.
  - `vblank` rises at vcount=160, with one `vblank_start` pulse per frame.
  - No `wen` is asserted while in either blank.
- `lyc`=100:
  - `vcount_match` is high for exactly 308*4 cycles per frame.
  - `lyc`=227 matches the last line.
- Random `en` stalls (around 30% low):
  - The sequence of (hcount, vcount, graphics_addr) at each `wen` is identical to the unstalled run.
  - No pulse is asserted while `en`=0.
- CONTINUOUS=0:
  - Idle with `busy`=0 until `start`.
  - After one frame, `busy` falls in the cycle after `toggle` and counters stay 0.
  - A `start` issued during RUN is ignored.
  - A second `start` runs a second frame.
- Reset asserted at vcount 50, hcount 17: next cycle all counters are 0, no `toggle` is emitted, and the next frame completes normally. Repeat with small geometry H_TOTAL=6, H_ACTIVE=4, V_TOTAL=3, V_ACTIVE=2, CPP=1 and check the full trace cycle by cycle.

Source files
------------

// File: rtl/gfx_scan_pkg.sv
// Shared types and default geometry for the scan-timing generator.
package gfx_scan_pkg;

    typedef enum logic {IDLE, RUN} scan_state_t;

    localparam int unsigned GBA_H_ACTIVE = 240;
    localparam int unsigned GBA_V_ACTIVE = 160;
    localparam int unsigned GBA_H_TOTAL  = 308;
    localparam int unsigned GBA_V_TOTAL  = 228;
    localparam int unsigned GBA_CPP      = 4;

endpackage

// File: rtl/scan_counter.sv
// Wrapping up-counter 0..MAX with clear and hold; `last` flags the terminal value.
module scan_counter #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned MAX   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] Q,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign Q    = cnt_q;
    assign last = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!en) begin
            cnt_d = cnt_q;
        end else if (last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gfx_scan_driver.sv
// Scan-timing generator: pixel/line counters, blanking decodes, framebuffer
// write address/strobe, end-of-frame buffer toggle and line-compare flag.
module gfx_scan_driver
    import gfx_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = GBA_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = GBA_V_ACTIVE,
    parameter int unsigned H_TOTAL    = GBA_H_TOTAL,
    parameter int unsigned V_TOTAL    = GBA_V_TOTAL,
    parameter int unsigned CPP        = GBA_CPP,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned V_W        = 8,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       start,
    input  logic [V_W-1:0]             lyc,
    output logic [$clog2(H_TOTAL)-1:0] hcount,
    output logic [V_W-1:0]             vcount,
    output logic [ADDR_W-1:0]          graphics_addr,
    output logic                       wen,
    output logic                       hblank,
    output logic                       vblank,
    output logic                       hblank_start,
    output logic                       vblank_start,
    output logic                       toggle,
    output logic                       vcount_match,
    output logic                       busy
);

    localparam int unsigned H_W   = $clog2(H_TOTAL);
    localparam int unsigned SUB_W = (CPP > 1) ? $clog2(CPP) : 1;

    localparam logic [H_W-1:0] H_ACT_V  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_HBS_V  = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0] V_ACT_V  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_VBS_V  = V_W'(V_ACTIVE - 1);

    scan_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [SUB_W-1:0] sub;
    logic sub_last, h_last, v_last;
    logic run, idle, last_sub, line_end, active;

    assign run  = (state_q == RUN);
    assign idle = !run;

    // Reset gating keeps every pulse quiet while reset is held.
    assign last_sub = sub_last & run & en & !reset;
    assign line_end = last_sub & h_last;

    scan_counter #(.WIDTH(SUB_W), .MAX(CPP - 1)) u_sub (
        .clock (clock),
        .reset (reset),
        .en    (run & en),
        .clear (idle),
        .Q     (sub),
        .last  (sub_last)
    );

    scan_counter #(.WIDTH(H_W), .MAX(H_TOTAL - 1)) u_hcount (
        .clock (clock),
        .reset (reset),
        .en    (last_sub),
        .clear (idle),
        .Q     (hcount),
        .last  (h_last)
    );

    scan_counter #(.WIDTH(V_W), .MAX(V_TOTAL - 1)) u_vcount (
        .clock (clock),
        .reset (reset),
        .en    (line_end),
        .clear (idle),
        .Q     (vcount),
        .last  (v_last)
    );

    assign hblank        = (hcount >= H_ACT_V);
    assign vblank        = (vcount >= V_ACT_V);
    assign active        = !hblank & !vblank;
    assign wen           = active & last_sub;
    assign hblank_start  = last_sub & (hcount == H_HBS_V);
    assign vblank_start  = line_end & (vcount == V_VBS_V);
    assign toggle        = line_end & v_last;
    assign vcount_match  = (vcount == lyc);
    assign busy          = run;
    assign graphics_addr = addr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!CONTINUOUS && toggle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (toggle) begin
            addr_d = '0;
        end else if (wen) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CONTINUOUS ? RUN : IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule
